regfile_writeback: RTL

//  Writeback end of the execute/writeback interface. Consumes the ALU output mux result, writeback enable and opcode.

---
 rtl/regfile_writeback_if.sv | 32 +++
 rtl/regfile_writeback.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile_writeback_if.sv
// Execute/writeback handshake bundle for regfile_writeback.
//   master: execute stage / decode side (drives ops, stall, PC, read addresses)
//   slave : writeback block (returns read data, redirect and squash status)
interface regfile_writeback_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              wb_valid;
  logic              wb_enable;
  logic [4:0]        wb_opcode;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic [DATA_W-1:0] pc_in;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;
  logic              squashing;

  modport master (
    output wb_valid, wb_enable, wb_opcode, wb_rd, wb_data, stall, pc_in, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, branch_taken, branch_target, squashing
  );

  modport slave (
    input  wb_valid, wb_enable, wb_opcode, wb_rd, wb_data, stall, pc_in, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, branch_taken, branch_target, squashing
  );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback stage and register file.
// Captures the execute-stage op into a WB stage, commits it one cycle later to a
// 2**ADDR_W-entry register file (top index is the PC), turns branches and PC writes
// into a one-cycle redirect pulse and squashes the next FLUSH_DEPTH accepted ops.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of regfile_writeback_if (op in, stall, pc_in,
//                two bypassed read ports, branch_taken/branch_target, squashing)
module regfile_writeback #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned PC_OFFSET   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_writeback_if.slave   bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned CntW    = $clog2(FLUSH_DEPTH + 1);
  localparam logic [4:0]  OpBranch = 5'b10001;
  localparam logic [ADDR_W-1:0] PcIdx = ADDR_W'(NumRegs - 1);

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  logic              stage_valid_q, stage_valid_d;
  logic              stage_en_q, stage_en_d;
  logic [4:0]        stage_op_q, stage_op_d;
  logic [ADDR_W-1:0] stage_rd_q, stage_rd_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic [CntW-1:0]   flush_cnt_q, flush_cnt_d;
  logic              branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0] branch_target_q, branch_target_d;

  logic stage_redirect;
  logic commit;
  logic bypass_ok;

  // Branch opcode or a write to the PC register both redirect fetch.
  assign stage_redirect = (stage_op_q == OpBranch) || (stage_rd_q == PcIdx);
  assign commit         = !bus.stall && stage_valid_q && stage_en_q;
  assign bypass_ok      = stage_valid_q && stage_en_q && !stage_redirect;

  always_comb begin
    regs_d          = regs_q;
    stage_valid_d   = stage_valid_q;
    stage_en_d      = stage_en_q;
    stage_op_d      = stage_op_q;
    stage_rd_d      = stage_rd_q;
    stage_data_d    = stage_data_q;
    flush_cnt_d     = flush_cnt_q;
    branch_taken_d  = 1'b0;
    branch_target_d = branch_target_q;

    if (commit) begin
      if (stage_redirect) begin
        branch_taken_d  = 1'b1;
        branch_target_d = stage_data_q;
        flush_cnt_d     = CntW'(FLUSH_DEPTH);
      end else begin
        regs_d[stage_rd_q] = stage_data_q;
      end
    end

    // Accept uses the post-commit counter so an op arriving with a redirect is
    // already counted as the first squashed one.
    if (!bus.stall) begin
      if (bus.wb_valid) begin
        if (flush_cnt_d != '0) begin
          stage_valid_d = 1'b0;
          flush_cnt_d   = flush_cnt_d - 1'b1;
        end else begin
          stage_valid_d = 1'b1;
          stage_en_d    = bus.wb_enable;
          stage_op_d    = bus.wb_opcode;
          stage_rd_d    = bus.wb_rd;
          stage_data_d  = bus.wb_data;
        end
      end else begin
        stage_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      stage_valid_q   <= 1'b0;
      stage_en_q      <= 1'b0;
      stage_op_q      <= '0;
      stage_rd_q      <= '0;
      stage_data_q    <= '0;
      flush_cnt_q     <= '0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      regs_q          <= regs_d;
      stage_valid_q   <= stage_valid_d;
      stage_en_q      <= stage_en_d;
      stage_op_q      <= stage_op_d;
      stage_rd_q      <= stage_rd_d;
      stage_data_q    <= stage_data_d;
      flush_cnt_q     <= flush_cnt_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == PcIdx) begin
      return bus.pc_in + DATA_W'(PC_OFFSET);
    end else if (bypass_ok && (stage_rd_q == addr)) begin
      return stage_data_q;
    end else begin
      return regs_q[addr];
    end
  endfunction

  always_comb begin
    bus.rd_data_a = read_port(bus.rd_addr_a);
    bus.rd_data_b = read_port(bus.rd_addr_b);
  end

  assign bus.branch_taken  = branch_taken_q;
  assign bus.branch_target = branch_target_q;
  assign bus.squashing     = (flush_cnt_q != '0);

endmodule
